// File: rtl/dp_sequencer.sv
// dp_sequencer
// Multi-cycle controller that runs one ARM data-processing instruction using
// an external combinational ALU and a single-read-port register file.
// Sequence: IDLE -> COND -> RD_RN -> RD_RM -> EXEC -> WB -> DONE -> IDLE.
// Every output is registered, so each output becomes visible one cycle after
// the state that computes it. Counting the accept edge as cycle 0: write
// strobes appear in cycle 5 and done in cycle 6. A failed condition or an
// undefined encoding raises done in cycle 2.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   start, instr, cpsr_flags request, instruction word, {N,Z,C,V}; sampled in IDLE
//   busy, done               busy from accept through done; one-cycle done pulse
//   rf_raddr / rf_rdata      register file read port (data one cycle after address)
//   rf_we, rf_waddr, rf_wdata register write port
//   alu_opcode, alu_a, alu_b, alu_flags / alu_out, alu_nzcv   ALU interface
//   flags_we, flags_out      CPSR NZCV write
//   pc_write                 asserted together with rf_we when Rd == r15
//   undef                    one-cycle pulse for an unsupported encoding
module dp_sequencer #(
  parameter int RF_AW = 4,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      instr,
  input  logic [3:0]       cpsr_flags,
  output logic             busy,
  output logic             done,
  output logic [RF_AW-1:0] rf_raddr,
  input  logic [DW-1:0]    rf_rdata,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [DW-1:0]    rf_wdata,
  output logic [3:0]       alu_opcode,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  output logic [3:0]       alu_flags,
  input  logic [DW-1:0]    alu_out,
  input  logic [3:0]       alu_nzcv,
  output logic             flags_we,
  output logic [3:0]       flags_out,
  output logic             pc_write,
  output logic             undef
);

  typedef enum logic [2:0] {
    S_IDLE, S_COND, S_RD_RN, S_RD_RM, S_EXEC, S_WB, S_DONE
  } state_t;

  state_t           state_q;
  logic [3:0]       cond_q;      // instr[31:28]
  logic [25:0]      ins_q;       // instr[25:0]; bits 27:26 are always 00
  logic [3:0]       cpsr_q;
  logic [DW-1:0]    op_a_q;
  logic             busy_q, done_q, rf_we_q, flags_we_q, pc_write_q, undef_q;
  logic [RF_AW-1:0] rf_raddr_q, rf_waddr_q;
  logic [DW-1:0]    rf_wdata_q, alu_a_q, alu_b_q;
  logic [3:0]       alu_opcode_q, alu_flags_q, flags_out_q;

  // Field decode of the latched instruction
  logic       i_bit, s_bit;
  logic [3:0] opcode, rn, rd, rot, rm;
  logic [7:0] imm8;
  assign i_bit  = ins_q[25];
  assign opcode = ins_q[24:21];
  assign s_bit  = ins_q[20];
  assign rn     = ins_q[19:16];
  assign rd     = ins_q[15:12];
  assign rot    = ins_q[11:8];
  assign imm8   = ins_q[7:0];
  assign rm     = ins_q[3:0];

  // Immediate operand: imm8 rotated right by 2*rot. A shift by 32 yields 0,
  // so rot == 0 correctly leaves the value unrotated.
  logic [4:0]  rot_amt;
  logic [31:0] imm32, rot_imm;
  assign rot_amt = {rot, 1'b0};
  assign imm32   = {24'd0, imm8};
  assign rot_imm = (imm32 >> rot_amt) | (imm32 << (6'd32 - {1'b0, rot_amt}));

  // Condition evaluation against the latched flags
  logic n_f, z_f, c_f, v_f, cond_pass;
  assign {n_f, z_f, c_f, v_f} = cpsr_q;

  always_comb begin
    cond_pass = 1'b0;
    case (cond_q)
      4'h0: cond_pass = z_f;
      4'h1: cond_pass = !z_f;
      4'h2: cond_pass = c_f;
      4'h3: cond_pass = !c_f;
      4'h4: cond_pass = n_f;
      4'h5: cond_pass = !n_f;
      4'h6: cond_pass = v_f;
      4'h7: cond_pass = !v_f;
      4'h8: cond_pass = c_f && !z_f;
      4'h9: cond_pass = !c_f || z_f;
      4'hA: cond_pass = (n_f == v_f);
      4'hB: cond_pass = (n_f != v_f);
      4'hC: cond_pass = !z_f && (n_f == v_f);
      4'hD: cond_pass = z_f || (n_f != v_f);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;   // 1111: never
    endcase
  end

  // Logical ops take C from the shifter when the immediate is really rotated.
  logic is_logical, c_from_shifter, wb_en, new_c;
  assign is_logical     = (opcode inside {4'h0, 4'h1, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF});
  assign c_from_shifter = is_logical && i_bit && (rot != 4'd0);
  assign new_c          = c_from_shifter ? rot_imm[31] : alu_nzcv[1];
  assign wb_en          = (opcode[3:2] != 2'b10);   // TST/TEQ/CMP/CMN only set flags

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch below sees the values from before this clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cond_q       <= '0;
      ins_q        <= '0;
      cpsr_q       <= '0;
      op_a_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rf_we_q      <= 1'b0;
      flags_we_q   <= 1'b0;
      pc_write_q   <= 1'b0;
      undef_q      <= 1'b0;
      rf_raddr_q   <= '0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      alu_flags_q  <= '0;
      flags_out_q  <= '0;
    end else begin
      // Pulse outputs drop back to zero unless a state raises them.
      done_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      flags_we_q <= 1'b0;
      pc_write_q <= 1'b0;
      undef_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= start;
          if (start) begin
            cond_q  <= instr[31:28];
            ins_q   <= instr[25:0];
            cpsr_q  <= cpsr_flags;
            state_q <= S_COND;
          end
        end
        S_COND: begin
          if (!cond_pass) begin
            state_q <= S_DONE;
          end else if (!i_bit && (ins_q[11:4] != 8'd0)) begin
            undef_q <= 1'b1;           // shifted-register operand not supported
            state_q <= S_DONE;
          end else begin
            rf_raddr_q <= RF_AW'(rn);
            state_q    <= S_RD_RN;
          end
        end
        S_RD_RN: begin
          // Rm address goes out while the Rn data is on its way back.
          if (!i_bit) rf_raddr_q <= RF_AW'(rm);
          state_q <= S_RD_RM;
        end
        S_RD_RM: begin
          op_a_q  <= rf_rdata;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          alu_a_q      <= op_a_q;
          alu_b_q      <= i_bit ? DW'(rot_imm) : rf_rdata;
          alu_opcode_q <= opcode;
          alu_flags_q  <= cpsr_q;
          state_q      <= S_WB;
        end
        S_WB: begin
          // The ALU settles on the operands registered in EXEC during this
          // cycle; its result is captured straight into the write registers.
          rf_we_q     <= wb_en;
          rf_waddr_q  <= RF_AW'(rd);
          rf_wdata_q  <= alu_out;
          pc_write_q  <= wb_en && (rd == 4'd15);
          flags_we_q  <= s_bit;
          flags_out_q <= {alu_nzcv[3:2], new_c, alu_nzcv[0]};
          state_q     <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rf_raddr   = rf_raddr_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_flags  = alu_flags_q;
  assign flags_we   = flags_we_q;
  assign flags_out  = flags_out_q;
  assign pc_write   = pc_write_q;
  assign undef      = undef_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer
// Self-checking bench for dp_sequencer. Provides a behavioural ALU and a
// register file with one-cycle read latency. Each instruction pushes its
// expected outcome to a scoreboard queue; the entry is popped and compared
// when the DUT signals done.
module tb_dp_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] instr;
  logic [3:0]  cpsr_flags;
  logic        busy, done, rf_we, flags_we, pc_write, undef;
  logic [3:0]  rf_raddr, rf_waddr, alu_opcode, alu_flags, alu_nzcv, flags_out;
  logic [31:0] rf_rdata, rf_wdata, alu_a, alu_b, alu_out;

  always #5 clk = ~clk;

  dp_sequencer #(.RF_AW(4), .DW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .cpsr_flags(cpsr_flags),
    .busy(busy), .done(done), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_flags(alu_flags),
    .alu_out(alu_out), .alu_nzcv(alu_nzcv), .flags_we(flags_we),
    .flags_out(flags_out), .pc_write(pc_write), .undef(undef)
  );

  // ---------------- environment: register file and ALU ----------------
  logic [31:0] regs [16] = '{32'h0000_0000, 32'h1111_1111, 32'h0000_0001, 32'h8000_0001,
                             32'h4444_4444, 32'h5555_5555, 32'hFFFF_FFFF, 32'h0000_0001,
                             32'h8888_8888, 32'h9999_9999, 32'hAAAA_AAAA, 32'hBBBB_BBBB,
                             32'hCCCC_CCCC, 32'hDDDD_DDDD, 32'hEEEE_EEEE, 32'h0000_0000};

  always @(posedge clk) begin
    rf_rdata <= regs[rf_raddr];
    if (rf_we) regs[rf_waddr] <= rf_wdata;
  end

  // {V, C, result}
  function automatic logic [33:0] addc(logic [31:0] a, logic [31:0] b, logic ci);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    return {(a[31] == b[31]) && (s[31] != a[31]), s};
  endfunction

  // Returns {N,Z,C,V, result}
  function automatic logic [35:0] alu_f(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                       logic [3:0] f);
    logic [33:0] x;
    logic [31:0] r;
    logic        cc, vv;
    cc = f[1];
    vv = f[0];
    x  = '0;
    r  = '0;
    case (op)
      4'h0, 4'h8: r = a & b;
      4'h1, 4'h9: r = a ^ b;
      4'h2, 4'hA: x = addc(a, ~b, 1'b1);
      4'h3:       x = addc(b, ~a, 1'b1);
      4'h4, 4'hB: x = addc(a, b, 1'b0);
      4'h5:       x = addc(a, b, f[1]);
      4'h6:       x = addc(a, ~b, f[1]);
      4'h7:       x = addc(b, ~a, f[1]);
      4'hC:       r = a | b;
      4'hD:       r = b;
      4'hE:       r = a & ~b;
      default:    r = ~b;
    endcase
    if (op inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB}) begin
      r  = x[31:0];
      cc = x[32];
      vv = x[33];
    end
    return {r[31], (r == 32'd0), cc, vv, r};
  endfunction

  logic [35:0] alu_res;
  assign alu_res  = alu_f(alu_opcode, alu_a, alu_b, alu_flags);
  assign alu_out  = alu_res[31:0];
  assign alu_nzcv = alu_res[35:32];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- scoreboard model ----------------
  typedef struct {
    int          done_cyc;
    bit          we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    bit          pc;
    bit          fwe;
    logic [3:0]  flags;
    bit          undef;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] dp(logic [3:0] cond, logic i, logic [3:0] op, logic s,
                                     logic [3:0] rn, logic [3:0] rd, logic [11:0] op2);
    return {cond, 2'b00, i, op, s, rn, rd, op2};
  endfunction

  function automatic exp_t model(logic [31:0] iw, logic [3:0] cp);
    exp_t        e;
    bit          pass;
    logic        n, z, c, v;
    logic [31:0] imm, a, b;
    logic [35:0] r;
    {n, z, c, v} = cp;
    e = '{default: 0};
    e.done_cyc = 2;
    case (iw[31:28])
      4'h0: pass = z;              4'h1: pass = !z;
      4'h2: pass = c;              4'h3: pass = !c;
      4'h4: pass = n;              4'h5: pass = !n;
      4'h6: pass = v;              4'h7: pass = !v;
      4'h8: pass = c && !z;        4'h9: pass = !c || z;
      4'hA: pass = (n == v);       4'hB: pass = (n != v);
      4'hC: pass = !z && (n == v); 4'hD: pass = z || (n != v);
      4'hE: pass = 1'b1;           default: pass = 1'b0;
    endcase
    if (!pass) return e;
    if (!iw[25] && iw[11:4] != 8'd0) begin
      e.undef = 1'b1;
      return e;
    end
    imm = {24'd0, iw[7:0]};
    for (int k = 0; k < 2 * int'(iw[11:8]); k++) imm = {imm[0], imm[31:1]};
    a = regs[iw[19:16]];
    b = iw[25] ? imm : regs[iw[3:0]];
    r = alu_f(iw[24:21], a, b, cp);
    e.done_cyc = 6;
    e.we    = !(iw[24:21] inside {4'h8, 4'h9, 4'hA, 4'hB});
    e.waddr = iw[15:12];
    e.wdata = r[31:0];
    e.pc    = e.we && (iw[15:12] == 4'hF);
    e.fwe   = iw[20];
    e.flags = r[35:32];
    if (iw[24:21] inside {4'h0, 4'h1, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF} &&
        iw[25] && iw[11:8] != 4'd0)
      e.flags[1] = imm[31];
    return e;
  endfunction

  // Drive one instruction, watch outputs each cycle (sampled at negedge,
  // cycle k = k-th negedge after the accept edge), then pop and compare.
  task automatic run_instr(input string name, input logic [31:0] iw, input logic [3:0] cp,
                           input bit noise);
    exp_t        e;
    int          done_c, we_n, we_c, fwe_n, fwe_c, und_n, und_c, pc_bad;
    logic        busy0, busy_d, pcw;
    logic [3:0]  waddr_s, flags_s;
    logic [31:0] wdata_s;
    sb.push_back(model(iw, cp));
    done_c = -1; we_n = 0; we_c = -1; fwe_n = 0; fwe_c = -1; und_n = 0; und_c = -1;
    pc_bad = 0; busy0 = 0; busy_d = 0; pcw = 0; waddr_s = '0; flags_s = '0; wdata_s = '0;
    @(negedge clk);
    instr = iw; cpsr_flags = cp; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        busy0 = busy;
      end
      if (noise && k == 2) begin       // request while busy must be ignored
        start = 1'b1;
        instr = dp(4'hE, 1'b1, 4'hD, 1'b1, 4'h0, 4'h0, 12'h0FF);
      end
      if (noise && k == 3) start = 1'b0;
      if (rf_we) begin
        we_n++; we_c = k; waddr_s = rf_waddr; wdata_s = rf_wdata; pcw = pc_write;
      end
      if (pc_write && !rf_we) pc_bad++;
      if (flags_we) begin
        fwe_n++; fwe_c = k; flags_s = flags_out;
      end
      if (undef) begin
        und_n++; und_c = k;
      end
      if (done) begin
        done_c = k;
        busy_d = busy;
        break;
      end
    end
    @(negedge clk);
    e = sb.pop_front();
    check({name, ".done_cycle"}, done_c, e.done_cyc);
    check({name, ".busy"}, {busy0, busy_d}, 2'b11);
    check({name, ".idle_after"}, {done, busy}, 2'b00);
    check({name, ".pc_without_we"}, pc_bad, 0);
    check({name, ".we_count"}, we_n, int'(e.we));
    if (e.we) begin
      check({name, ".we_cycle"}, we_c, 5);
      check({name, ".waddr"}, waddr_s, e.waddr);
      check({name, ".wdata"}, wdata_s, e.wdata);
      check({name, ".pc_write"}, pcw, e.pc);
    end
    check({name, ".flags_we_count"}, fwe_n, int'(e.fwe));
    if (e.fwe) begin
      check({name, ".flags_we_cycle"}, fwe_c, 5);
      check({name, ".flags"}, flags_s, e.flags);
    end
    check({name, ".undef_count"}, und_n, int'(e.undef));
    if (e.undef) check({name, ".undef_cycle"}, und_c, 1);
  endtask

  // ---------------- stimulus ----------------
  int seen_wr;

  initial begin
    rst = 1'b1; start = 1'b0; instr = '0; cpsr_flags = '0;
    repeat (3) @(negedge clk);
    check("reset.pulses", {busy, done, rf_we, flags_we, pc_write, undef}, 6'd0);
    check("reset.addr_op", {rf_raddr, rf_waddr, alu_opcode, alu_flags, flags_out}, 20'd0);
    check("reset.alu_a", alu_a, 32'd0);
    check("reset.alu_b", alu_b, 32'd0);
    check("reset.wdata", rf_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of an instruction abandons it without any write.
    instr = dp(4'hE, 1'b1, 4'h4, 1'b1, 4'h2, 4'hC, 12'h001); cpsr_flags = 4'h0; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("rst_mid.busy", busy, 1'b0);
    seen_wr = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rf_we || flags_we) seen_wr++;
      if (k == 1) rst = 1'b0;
    end
    check("rst_mid.no_write", seen_wr, 0);
    run_instr("after_rst_adds", dp(4'hE, 1'b1, 4'h4, 1'b1, 4'h2, 4'hC, 12'h001), 4'h0, 1'b0);

    run_instr("adds_imm",   dp(4'hE, 1'b1, 4'h4, 1'b1, 4'h2, 4'h1, 12'h0FF), 4'h0, 1'b0);
    run_instr("movs_rot5",  dp(4'hE, 1'b1, 4'hD, 1'b1, 4'h0, 4'h0, 12'h5FF), 4'h2, 1'b0);
    run_instr("movs_rot1",  dp(4'hE, 1'b1, 4'hD, 1'b1, 4'h0, 4'h4, 12'h1FF), 4'h0, 1'b0);
    run_instr("cmp_r3_r3",  dp(4'hE, 1'b0, 4'hA, 1'b1, 4'h3, 4'h0, 12'h003), 4'h0, 1'b0);
    run_instr("addeq_fail", dp(4'h0, 1'b0, 4'h4, 1'b0, 4'h0, 4'h0, 12'h000), 4'h0, 1'b0);
    run_instr("addeq_pass", dp(4'h0, 1'b0, 4'h4, 1'b0, 4'h0, 4'h0, 12'h000), 4'h4, 1'b0);
    run_instr("add_lsl",    dp(4'hE, 1'b0, 4'h4, 1'b0, 4'h1, 4'h0, 12'h082), 4'h0, 1'b0);
    run_instr("mov_pc",     dp(4'hE, 1'b1, 4'hD, 1'b0, 4'h0, 4'hF, 12'h008), 4'h0, 1'b1);
    run_instr("adcs_reg",   dp(4'hE, 1'b0, 4'h5, 1'b1, 4'h6, 4'h5, 12'h007), 4'h2, 1'b0);
    run_instr("subs_reg",   dp(4'hE, 1'b0, 4'h2, 1'b1, 4'h2, 4'h8, 12'h003), 4'h0, 1'b0);
    run_instr("eors_rot0",  dp(4'hE, 1'b1, 4'h1, 1'b1, 4'h6, 4'h9, 12'h00F), 4'h3, 1'b0);
    run_instr("never",      dp(4'hF, 1'b1, 4'hD, 1'b0, 4'h0, 4'h1, 12'h001), 4'h0, 1'b0);
    run_instr("gt_pass",    dp(4'hC, 1'b1, 4'h4, 1'b0, 4'h2, 4'hA, 12'h002), 4'h9, 1'b0);
    run_instr("lt_fail",    dp(4'hB, 1'b1, 4'h4, 1'b0, 4'h2, 4'hA, 12'h002), 4'h9, 1'b0);
    run_instr("hi_orrs",    dp(4'h8, 1'b0, 4'hC, 1'b1, 4'h6, 4'hB, 12'h007), 4'h2, 1'b0);
    run_instr("ls_fail",    dp(4'h9, 1'b0, 4'hC, 1'b1, 4'h6, 4'hB, 12'h007), 4'h2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
